// File: rtl/uart_tx_arbiter_if.sv
// Bundles the two byte sources, the uart FIFO write port and the arbiter status.
interface uart_tx_arbiter_if #(
    parameter int DBIT = 8
);
    logic            a_valid;
    logic [DBIT-1:0] a_data;
    logic            a_last;
    logic            a_ready;
    logic            b_valid;
    logic [DBIT-1:0] b_data;
    logic            b_last;
    logic            b_ready;
    logic            tx_full;
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic [1:0]      grant;
    logic            busy;
    logic            trunc;

    // Source / uart side: drives requests and FIFO status, observes the results.
    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, tx_full,
        input  a_ready, b_ready, wr_uart, w_data, grant, busy, trunc
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, tx_full,
        output a_ready, b_ready, wr_uart, w_data, grant, busy, trunc
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the uart TX FIFO write port
// between two byte sources.
//
// state | meaning
// IDLE  | no owner; arbitrate between pending sources (one cycle)
// OWN_A | source A owns the FIFO write port until release
// OWN_B | source B owns the FIFO write port until release
module uart_tx_arbiter #(
    parameter int DBIT    = 8,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 1000
) (
    input logic                 clk,
    input logic                 reset,
    uart_tx_arbiter_if.slave    bus
);
    localparam int BCW = $clog2(MAX_LEN + 1);
    localparam int SCW = $clog2(TIMEOUT + 1);

    // Encoding chosen so that the state register is directly the one-hot grant.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q;
    logic [BCW-1:0]  byte_cnt_q;
    logic [SCW-1:0]  stall_cnt_q;
    logic            trunc_q;

    logic            owned;
    logic            own_valid;
    logic            own_last;
    logic [DBIT-1:0] own_data;
    logic            xfer;
    logic            hit_cap;
    logic            stall_to;
    logic            forced;
    logic            release_now;

    // Owner-side view of the granted source plus release conditions.
    always_comb begin
        owned     = (state_q != IDLE);
        own_valid = (state_q == OWN_A) ? bus.a_valid :
                    (state_q == OWN_B) ? bus.b_valid : 1'b0;
        own_last  = (state_q == OWN_A) ? bus.a_last  : bus.b_last;
        own_data  = (state_q == OWN_A) ? bus.a_data  : bus.b_data;
        xfer      = owned && own_valid && !bus.tx_full;
        hit_cap   = xfer && (byte_cnt_q == BCW'(MAX_LEN - 1));
        stall_to  = owned && !own_valid && (stall_cnt_q == SCW'(TIMEOUT - 1));
        // A last byte landing on the cap is a normal release, not a truncation.
        forced      = (hit_cap && !own_last) || stall_to;
        release_now = (xfer && own_last) || hit_cap || stall_to;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: round-robin pick in IDLE, hold ownership until a release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.a_valid && (!bus.b_valid || !rr_q)) state_d = OWN_A;
                else if (bus.b_valid)                       state_d = OWN_B;
            end
            OWN_A, OWN_B: begin
                if (release_now) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin pointer, byte/stall counters and the truncation pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= 1'b0;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
            trunc_q     <= 1'b0;
        end else begin
            trunc_q <= forced;
            if (release_now) rr_q <= (state_q == OWN_A);

            if (!owned || release_now) byte_cnt_q <= '0;
            else if (xfer)             byte_cnt_q <= byte_cnt_q + 1'b1;

            // A full FIFO with valid data holds the stall count rather than advancing it.
            if (!owned || release_now || xfer) stall_cnt_q <= '0;
            else if (!own_valid)               stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Outputs: readies and FIFO write follow tx_full combinationally.
    always_comb begin
        bus.a_ready = (state_q == OWN_A) && !bus.tx_full;
        bus.b_ready = (state_q == OWN_B) && !bus.tx_full;
        bus.wr_uart = xfer;
        bus.w_data  = xfer ? own_data : '0;
        bus.grant   = state_q;
        bus.busy    = owned;
        bus.trunc   = trunc_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with MAX_LEN=4, TIMEOUT=8.
module tb_uart_tx_arbiter;
    localparam int DBIT = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_arbiter_if #(.DBIT(DBIT)) bus_if ();

    uart_tx_arbiter #(.DBIT(DBIT), .MAX_LEN(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Packet descriptors for the two sources and the per-cycle expectation table.
    int          a_n, b_n;
    logic [7:0]  a_bytes [16];
    logic [7:0]  b_bytes [16];
    logic [15:0] a_lastv, b_lastv;
    logic [1:0]  exp_g [32];
    logic [7:0]  exp_d [32];
    logic        exp_t [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus_if.a_valid = 1'b0; bus_if.a_data = '0; bus_if.a_last = 1'b0;
        bus_if.b_valid = 1'b0; bus_if.b_data = '0; bus_if.b_last = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        bus_if.tx_full = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 32; i++) begin
            exp_g[i] = 2'b00; exp_d[i] = 8'h00; exp_t[i] = 1'b0;
        end
        a_n = 0; b_n = 0; a_lastv = '0; b_lastv = '0;
    endtask

    task automatic set_row(input int c, input logic [1:0] g, input logic [7:0] d, input logic t);
        exp_g[c] = g; exp_d[c] = d; exp_t[c] = t;
    endtask

    // Sources present their next byte and advance on a completed handshake.
    task automatic run_table(input int ncyc, input string tag);
        int ai = 0;
        int bi = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus_if.a_valid = (ai < a_n);
            bus_if.a_data  = (ai < a_n) ? a_bytes[ai] : 8'h00;
            bus_if.a_last  = (ai < a_n) ? a_lastv[ai] : 1'b0;
            bus_if.b_valid = (bi < b_n);
            bus_if.b_data  = (bi < b_n) ? b_bytes[bi] : 8'h00;
            bus_if.b_last  = (bi < b_n) ? b_lastv[bi] : 1'b0;
            #1;
            chk($sformatf("%s_grant_c%0d", tag, c), 32'(bus_if.grant), 32'(exp_g[c]));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(bus_if.busy), 32'(exp_g[c] != 2'b00));
            chk($sformatf("%s_wr_c%0d", tag, c), 32'(bus_if.wr_uart), 32'(exp_d[c] != 8'h00));
            chk($sformatf("%s_wdata_c%0d", tag, c), 32'(bus_if.w_data), 32'(exp_d[c]));
            chk($sformatf("%s_trunc_c%0d", tag, c), 32'(bus_if.trunc), 32'(exp_t[c]));
            if (bus_if.a_valid && bus_if.a_ready) ai++;
            if (bus_if.b_valid && bus_if.b_ready) bi++;
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_if.tx_full = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus_if.grant), 32'h0);
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_trunc", 32'(bus_if.trunc), 32'h0);
        chk("rst_wr", 32'(bus_if.wr_uart), 32'h0);
        chk("rst_wdata", 32'(bus_if.w_data), 32'h0);
        chk("rst_ready", 32'({bus_if.a_ready, bus_if.b_ready}), 32'h0);
        reset = 1'b0;

        // A sends 0x41,0x42,0x43 with last on the third byte.
        clear_tbl();
        a_n = 3; a_bytes[0] = 8'h41; a_bytes[1] = 8'h42; a_bytes[2] = 8'h43; a_lastv = 16'b100;
        set_row(1, 2'b01, 8'h41, 0);
        set_row(2, 2'b01, 8'h42, 0);
        set_row(3, 2'b01, 8'h43, 0);
        run_table(6, "pkt3");

        // Both sources with three 2-byte packets each: A,B,A,B,A,B with idle gaps.
        reset_dut();
        clear_tbl();
        a_n = 6; b_n = 6; a_lastv = 16'b101010; b_lastv = 16'b101010;
        for (int i = 0; i < 6; i++) begin
            a_bytes[i] = 8'hA0 + 8'(i);
            b_bytes[i] = 8'hB0 + 8'(i);
        end
        set_row(1, 2'b01, 8'hA0, 0);  set_row(2, 2'b01, 8'hA1, 0);
        set_row(4, 2'b10, 8'hB0, 0);  set_row(5, 2'b10, 8'hB1, 0);
        set_row(7, 2'b01, 8'hA2, 0);  set_row(8, 2'b01, 8'hA3, 0);
        set_row(10, 2'b10, 8'hB2, 0); set_row(11, 2'b10, 8'hB3, 0);
        set_row(13, 2'b01, 8'hA4, 0); set_row(14, 2'b01, 8'hA5, 0);
        set_row(16, 2'b10, 8'hB4, 0); set_row(17, 2'b10, 8'hB5, 0);
        run_table(19, "rr");

        // FIFO full for 50 cycles mid-packet: no writes, no release.
        reset_dut();
        @(negedge clk);
        bus_if.a_valid = 1'b1; bus_if.a_data = 8'h51; bus_if.a_last = 1'b0;
        @(negedge clk);
        #1;
        chk("full_first_wdata", 32'(bus_if.w_data), 32'h51);
        @(negedge clk);
        bus_if.a_data = 8'h52;
        bus_if.tx_full = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk($sformatf("full_hold_%0d", i),
                32'({bus_if.a_ready, bus_if.wr_uart, bus_if.grant, bus_if.trunc}), 32'b00010);
            @(negedge clk);
        end
        bus_if.tx_full = 1'b0;
        #1;
        chk("full_resume_wr", 32'(bus_if.wr_uart), 32'h1);
        chk("full_resume_wdata", 32'(bus_if.w_data), 32'h52);
        @(negedge clk);
        bus_if.a_data = 8'h53; bus_if.a_last = 1'b1;
        #1;
        chk("full_last_wdata", 32'(bus_if.w_data), 32'h53);
        @(negedge clk);
        drive_idle();
        #1;
        chk("full_release", 32'({bus_if.grant, bus_if.trunc}), 32'h0);

        // Length cap of 4: B's 6-byte stream is cut after 0x13, remainder re-granted.
        reset_dut();
        clear_tbl();
        b_n = 6; b_lastv = 16'b100000;
        for (int i = 0; i < 6; i++) b_bytes[i] = 8'h10 + 8'(i);
        set_row(1, 2'b10, 8'h10, 0); set_row(2, 2'b10, 8'h11, 0);
        set_row(3, 2'b10, 8'h12, 0); set_row(4, 2'b10, 8'h13, 0);
        set_row(5, 2'b00, 8'h00, 1);
        set_row(6, 2'b10, 8'h14, 0); set_row(7, 2'b10, 8'h15, 0);
        run_table(10, "cap");

        // Timeout of 8: A stalls after one byte, pending B follows after the forced release.
        reset_dut();
        clear_tbl();
        a_n = 1; a_bytes[0] = 8'h61; a_lastv = 16'b0;
        b_n = 1; b_bytes[0] = 8'h71; b_lastv = 16'b1;
        set_row(1, 2'b01, 8'h61, 0);
        for (int c = 2; c <= 9; c++) set_row(c, 2'b01, 8'h00, 0);
        set_row(10, 2'b00, 8'h00, 1);
        set_row(11, 2'b10, 8'h71, 0);
        run_table(13, "tmo");

        // Reset while B owns the port with 2 of 5 bytes sent; rr must return to A.
        reset_dut();
        @(negedge clk);
        bus_if.a_valid = 1'b1; bus_if.a_data = 8'h81; bus_if.a_last = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_a_wdata", 32'(bus_if.w_data), 32'h81);
        @(negedge clk);
        drive_idle();
        bus_if.b_valid = 1'b1; bus_if.b_data = 8'h90;
        @(negedge clk);
        #1;
        chk("mrst_b0_grant", 32'(bus_if.grant), 32'h2);
        chk("mrst_b0_wdata", 32'(bus_if.w_data), 32'h90);
        @(negedge clk);
        bus_if.b_data = 8'h91;
        #1;
        chk("mrst_b1_wdata", 32'(bus_if.w_data), 32'h91);
        @(negedge clk);
        reset = 1'b1;
        bus_if.b_data = 8'h92;
        bus_if.a_valid = 1'b1; bus_if.a_data = 8'h82; bus_if.a_last = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_grant", 32'(bus_if.grant), 32'h0);
        chk("mrst_wr", 32'(bus_if.wr_uart), 32'h0);
        chk("mrst_trunc", 32'(bus_if.trunc), 32'h0);
        @(negedge clk);
        #1;
        chk("mrst_rr_a_first", 32'(bus_if.grant), 32'h1);
        chk("mrst_a_data", 32'(bus_if.w_data), 32'h82);
        @(negedge clk);
        drive_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
